// File: rtl/router_pkg.sv
// Shared types and sizes for the router input port: flit geometry, encapsulation FSM
// states and the header-flit packing helper.
package router_pkg;

    localparam int FLIT_W         = 64;
    localparam int DATA_W         = 1024;
    localparam int ADDR_W         = 10;
    localparam int HDR_W          = 9;
    localparam int FIFO_DEPTH     = 32;
    localparam int NUM_DATA_FLITS = DATA_W / FLIT_W;
    localparam int PKT_FLITS      = NUM_DATA_FLITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } encap_state_t;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO with a registered read port; pointers wrap modulo DEPTH.
module flit_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               din,
    input  logic                       rd_en,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          wr_ok, rd_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = dout_q;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        dout_d  = dout_q;
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) begin
            rptr_d = rptr_q + 1'b1;
            dout_d = mem[rptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q] <= din;
    end

endmodule

// File: rtl/input_port_0.sv
// Router input port: captures a granted packet, slices it into a header flit plus
// MSB-first data flits, and queues them for the downstream crossbar stage.
module input_port_0 #(
    parameter int FLIT_W     = router_pkg::FLIT_W,
    parameter int DATA_W     = router_pkg::DATA_W,
    parameter int ADDR_W     = router_pkg::ADDR_W,
    parameter int HDR_W      = router_pkg::HDR_W,
    parameter int FIFO_DEPTH = router_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arbiter_gnt,
    input  logic [DATA_W-1:0] data_arbiter_send,
    input  logic [ADDR_W-1:0] dst_addr_arbiter_send,
    input  logic [HDR_W-1:0]  header_pkt_send,
    input  logic              rd_en,
    output logic [FLIT_W-1:0] dout,
    output logic              empty,
    output logic              ready_encap_dfx
);

    import router_pkg::*;

    localparam int N_DATA  = DATA_W / FLIT_W;
    localparam int N_PKT   = N_DATA + 1;
    localparam int IDX_W   = $clog2(N_PKT);
    localparam int CHUNK_W = $clog2(N_DATA);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    encap_state_t             state_q, state_d;
    logic [DATA_W-1:0]        data_q, data_d;
    logic [ADDR_W-1:0]        dst_q, dst_d;
    logic [HDR_W-1:0]         hdr_q, hdr_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     ready_q, ready_d;

    logic [N_DATA-1:0][FLIT_W-1:0] chunks;
    logic [CHUNK_W-1:0]       chunk_sel;
    logic [FLIT_W-1:0]        flit;
    logic                     wr_en;
    logic                     fifo_full;
    logic [CNT_W-1:0]         fifo_count;

    assign chunks          = data_q;
    assign ready_encap_dfx = ready_q;

    // Flit k>=1 takes chunk N_DATA-k, so the most significant chunk leaves first.
    assign chunk_sel = CHUNK_W'(N_DATA - 32'(idx_q));

    always_comb begin
        if (idx_q == '0)
            flit = {hdr_q, dst_q, {(FLIT_W-HDR_W-ADDR_W){1'b0}}};
        else
            flit = chunks[chunk_sel];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dst_d   = dst_q;
        hdr_d   = hdr_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arbiter_gnt) begin
                    data_d  = data_arbiter_send;
                    dst_d   = dst_addr_arbiter_send;
                    hdr_d   = header_pkt_send;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wr_en = !fifo_full;
                if (idx_q == IDX_W'(N_PKT-1)) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // Leave once the final queued flit is popped this edge.
                if (empty || (rd_en && fifo_count == CNT_W'(1))) begin
                    state_d = IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            dst_q   <= '0;
            hdr_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dst_q   <= dst_d;
            hdr_q   <= hdr_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    flit_fifo #(
        .W     (FLIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_n),
        .wr_en (wr_en),
        .din   (flit),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_input_port_0.sv
// Directed bench for input_port_0: reset, encapsulation timing, drain order,
// ignored grants, concurrent fill/drain and reset during LOAD.
module tb_input_port_0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          arbiter_gnt;
    logic [1023:0] data_arbiter_send;
    logic [9:0]    dst_addr_arbiter_send;
    logic [8:0]    header_pkt_send;
    logic          rd_en;
    logic [63:0]   dout;
    logic          empty;
    logic          ready_encap_dfx;

    int errors = 0;
    int checks = 0;

    logic [1023:0] pa, pc, pd, pe;
    logic [63:0]   f_first, f_last, last_a;

    always #5 clk = ~clk;

    input_port_0 dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .arbiter_gnt           (arbiter_gnt),
        .data_arbiter_send     (data_arbiter_send),
        .dst_addr_arbiter_send (dst_addr_arbiter_send),
        .header_pkt_send       (header_pkt_send),
        .rd_en                 (rd_en),
        .dout                  (dout),
        .empty                 (empty),
        .ready_encap_dfx       (ready_encap_dfx)
    );

    function automatic logic [63:0] exp_flit(input logic [1023:0] d, input logic [9:0] a,
                                             input logic [8:0] h, input int k);
        if (k == 0) return {h, a, 45'b0};
        return d[1023-64*(k-1) -: 64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One-cycle grant; returns at the negedge following the capture edge.
    task automatic send(input logic [1023:0] d, input logic [9:0] a, input logic [8:0] h);
        @(negedge clk);
        arbiter_gnt = 1'b1;
        data_arbiter_send = d;
        dst_addr_arbiter_send = a;
        header_pkt_send = h;
        @(negedge clk);
        arbiter_gnt = 1'b0;
    endtask

    // Holds rd_en for 17 pops plus two idle-pop cycles, checking every flit.
    task automatic drain(input string tag, input logic [1023:0] d, input logic [9:0] a,
                         input logic [8:0] h, output logic [63:0] first, output logic [63:0] last);
        rd_en = 1'b1;
        first = '0;
        last  = '0;
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            chk($sformatf("%s_flit%0d", tag, j), dout, exp_flit(d, a, h, j));
            if (j == 0)  first = dout;
            if (j == 16) last  = dout;
        end
        chk({tag, "_empty_after"}, 64'(empty), 64'd1);
        chk({tag, "_ready_after"}, 64'(ready_encap_dfx), 64'd0);
        repeat (2) @(negedge clk);
        chk({tag, "_dout_hold"}, dout, last);
        chk({tag, "_empty_hold"}, 64'(empty), 64'd1);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        arbiter_gnt = 1'b0;
        rd_en = 1'b0;
        data_arbiter_send = '0;
        dst_addr_arbiter_send = '0;
        header_pkt_send = '0;

        for (int i = 0; i < 64; i++) begin
            logic [3:0] nib;
            nib = 4'(i % 9 + 1);
            pa[1023-16*i -: 16] = {4{nib}};
        end
        for (int i = 0; i < 16; i++)
            pc[1023-64*i -: 64] = {32'hC0DE0000 + 32'(i), 32'h0BAD0000 + 32'(i*3)};
        pd = ~pa;
        pe = pc ^ {16{64'h5A5A_A5A5_0F0F_F0F0}};

        // Reset state and idle pop
        repeat (2) @(negedge clk);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_dout", dout, 64'd0);
        chk("rst_ready", 64'(ready_encap_dfx), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        chk("idle_pop_dout", dout, 64'd0);
        chk("idle_pop_empty", 64'(empty), 64'd1);
        rd_en = 1'b0;

        // Packet A: timing of empty/ready, ignored grants in LOAD and DONE
        send(pa, 10'hA, 9'b100111101);
        chk("a_empty_at_capture", 64'(empty), 64'd1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) chk("a_empty_first_write", 64'(empty), 64'd0);
            chk($sformatf("a_ready_k%0d", k), 64'(ready_encap_dfx), (k == 17) ? 64'd1 : 64'd0);
            if (k == 5) begin
                arbiter_gnt = 1'b1;
                data_arbiter_send = pd;
                dst_addr_arbiter_send = 10'h3;
                header_pkt_send = 9'h5;
            end
            if (k == 6) arbiter_gnt = 1'b0;
        end
        arbiter_gnt = 1'b1;
        @(negedge clk);
        arbiter_gnt = 1'b0;
        chk("a_ready_done_gnt", 64'(ready_encap_dfx), 64'd1);
        drain("a", pa, 10'hA, 9'b100111101, f_first, f_last);
        chk("a_hdr_const", f_first, 64'h9E81400000000000);
        chk("a_last_const", f_last, 64'h7777888899991111);
        last_a = f_last;

        // Packet C back-to-back, popping while flits are still being written
        send(pc, 10'h3FF, 9'h1FF);
        rd_en = 1'b1;
        for (int m = 1; m <= 18; m++) begin
            @(negedge clk);
            if (m == 1) chk("c_dout_hold_prefill", dout, last_a);
            if (m >= 2) chk($sformatf("c_flit%0d", m - 2), dout, exp_flit(pc, 10'h3FF, 9'h1FF, m - 2));
            if (m == 2) chk("c_hdr_const", dout, 64'hFFFFE00000000000);
            if (m == 17) chk("c_ready_high", 64'(ready_encap_dfx), 64'd1);
            if (m == 18) begin
                chk("c_ready_low", 64'(ready_encap_dfx), 64'd0);
                chk("c_empty_end", 64'(empty), 64'd1);
            end
        end
        rd_en = 1'b0;

        // Packet D aborted by reset after flit 5 is written
        send(pd, 10'h2C1, 9'h033);
        repeat (6) @(negedge clk);
        chk("d_not_empty", 64'(empty), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("d_rst_empty", 64'(empty), 64'd1);
        chk("d_rst_ready", 64'(ready_encap_dfx), 64'd0);
        chk("d_rst_dout", dout, 64'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // Packet E after the aborted one
        send(pe, 10'h155, 9'h0AA);
        for (int t = 0; t < 40 && !ready_encap_dfx; t++) @(negedge clk);
        chk("e_ready_wait", 64'(ready_encap_dfx), 64'd1);
        drain("e", pe, 10'h155, 9'h0AA, f_first, f_last);
        chk("e_hdr_const", f_first, 64'h552AA00000000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
